// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings,
// the NOP word, the default reset PC and the presented-fetch record.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_out_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Holding register for a word fetched while decode is frozen.
module fetch_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one request in flight, zero-latency pass-through on ack,
// a hold buffer for frozen decode and a drain state for branches under a miss.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        fetch_valid,
  output logic        flush
);

  state_t      state, state_nxt;
  logic [31:0] pc_reg, pc_nxt;
  logic [31:0] pending_pc, pending_nxt;
  logic [31:0] pc_plus4, target;
  logic [31:0] buf_instr;
  logic        buf_load;
  logic        req;
  fetch_out_t  out;

  assign pc_plus4 = pc_reg + 32'd4;
  assign target   = align_word(branch_addr);

  fetch_buffer #(.W(32)) u_buf (
    .clk  (clk),
    .clr  (!rst),
    .load (buf_load),
    .d    (imem_rdata),
    .q    (buf_instr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_REQ;
      pc_reg     <= RESET_PC;
      pending_pc <= '0;
    end else begin
      state      <= state_nxt;
      pc_reg     <= pc_nxt;
      pending_pc <= pending_nxt;
    end
  end

  // Branch outranks freeze and ack in every state.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_reg;
    pending_nxt = pending_pc;
    buf_load    = 1'b0;
    req         = 1'b0;
    out         = '0;
    case (state)
      S_REQ: begin
        req = 1'b1;
        if (branch_taken) begin
          if (imem_ack) begin
            pc_nxt = target;
          end else begin
            pending_nxt = target;
            state_nxt   = S_DRAIN;
          end
        end else if (imem_ack) begin
          out.valid = 1'b1;
          out.pc    = pc_plus4;
          out.instr = imem_rdata;
          if (freeze) begin
            buf_load  = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_nxt    = target;
          state_nxt = S_REQ;
        end else begin
          out.valid = 1'b1;
          out.pc    = pc_plus4;
          out.instr = buf_instr;
          if (!freeze) begin
            pc_nxt    = pc_plus4;
            state_nxt = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        // Address stays on the abandoned PC until memory answers.
        req = 1'b1;
        if (branch_taken) pending_nxt = target;
        if (imem_ack) begin
          pc_nxt    = branch_taken ? target : pending_pc;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  assign imem_req    = rst && req;
  assign imem_addr   = rst ? pc_reg : RESET_PC;
  assign fetch_valid = rst && out.valid;
  assign instruction = (rst && out.valid) ? out.instr : NOP_WORD;
  assign PC          = (rst && out.valid) ? out.pc : 32'h0;
  assign flush       = rst && branch_taken;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// against a behavioural model of the fetch rules.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, freeze = 1'b0, branch_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req, fetch_valid, flush;
  logic [31:0] imem_addr, imem_rdata, PC, instruction;

  logic        rst2 = 1'b0;
  logic        imem_req2, fetch_valid2, flush2;
  logic [31:0] imem_addr2, imem_rdata2, PC2, instruction2;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(PC),
    .instruction(instruction), .fetch_valid(fetch_valid), .flush(flush)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .freeze(1'b0), .branch_taken(1'b0),
    .branch_addr(32'h0), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(1'b1), .imem_rdata(imem_rdata2), .PC(PC2),
    .instruction(instruction2), .fetch_valid(fetch_valid2), .flush(flush2)
  );

  // {req, addr, valid, flush, instr, pc}
  function automatic logic [98:0] obs();
    return {imem_req, imem_addr, fetch_valid, flush, instruction, PC};
  endfunction

  task automatic set_in(input logic r, input logic f, input logic b,
                        input logic [31:0] ba, input logic a);
    rst = r; freeze = f; branch_taken = b; branch_addr = ba; imem_ack = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [98:0] e;
    e = {1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    set_in(0, 1, 1, 32'h40, 1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", obs(), e);
    end
    tick();
    set_in(0, 0, 1, 32'h44, 0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_held got %h want %h", obs(), e);
    end
    tick();
  endtask

  task automatic test_zero_wait();
    logic [98:0] e;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 32'h0, 1);
      e = {1'b1, 32'(4*i), 1'b1, 1'b0, mem_word(32'(4*i)), 32'(4*i+4)};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL zero_wait[%0d] got %h want %h", i, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_freeze();
    set_in(0, 0, 0, 32'h0, 0); tick();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 32'h0, 1); tick();
    end
    set_in(1, 1, 0, 32'h0, 1);
    checks++;
    if ({imem_req, imem_addr, fetch_valid, instruction, PC} !== {1'b1, 32'h8, 1'b1, mem_word(32'h8), 32'hC}) begin
      errors++;
      $display("FAIL freeze_ack got req=%b addr=%h v=%b ins=%h pc=%h want addr 8 pc C", imem_req, imem_addr, fetch_valid, instruction, PC);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      set_in(1, 1, 0, 32'h0, 0);
      checks++;
      if ({imem_req, fetch_valid, flush, instruction, PC} !== {1'b0, 1'b1, 1'b0, mem_word(32'h8), 32'hC}) begin
        errors++;
        $display("FAIL freeze_hold[%0d] got req=%b v=%b ins=%h pc=%h want req 0 v 1 pc C", k, imem_req, fetch_valid, instruction, PC);
      end
      tick();
    end
    set_in(1, 0, 0, 32'h0, 0);
    checks++;
    if ({imem_req, fetch_valid, instruction, PC} !== {1'b0, 1'b1, mem_word(32'h8), 32'hC}) begin
      errors++;
      $display("FAIL freeze_release got req=%b v=%b ins=%h pc=%h", imem_req, fetch_valid, instruction, PC);
    end
    tick();
    set_in(1, 0, 0, 32'h0, 0);
    checks++;
    if (obs() !== {1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL freeze_next_req got %h want req=1 addr=C bubble", obs());
    end
    tick();
  endtask

  task automatic test_branch_drain();
    set_in(1, 0, 0, 32'h0, 1);
    checks++;
    if (obs() !== {1'b1, 32'hC, 1'b1, 1'b0, mem_word(32'hC), 32'h10}) begin
      errors++;
      $display("FAIL drain_pre got %h", obs());
    end
    tick();
    set_in(1, 0, 1, 32'h103, 0);
    checks++;
    if (obs() !== {1'b1, 32'h10, 1'b0, 1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL drain_branch got %h want flush=1 addr=10", obs());
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      set_in(1, 0, 0, 32'h0, 0);
      checks++;
      if (obs() !== {1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0}) begin
        errors++;
        $display("FAIL drain_wait[%0d] got %h want addr=10 req=1", k, obs());
      end
      tick();
    end
    set_in(1, 0, 0, 32'h0, 1);
    checks++;
    if (obs() !== {1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL drain_ack got %h want data discarded", obs());
    end
    tick();
    set_in(1, 0, 0, 32'h0, 0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL drain_target got req=%b addr=%h want addr 100", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_branch_freeze_ack();
    set_in(1, 1, 1, 32'h200, 1);
    checks++;
    if ({fetch_valid, flush, instruction, PC} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL bfa_present got v=%b fl=%b ins=%h pc=%h want v 0 fl 1", fetch_valid, flush, instruction, PC);
    end
    tick();
    set_in(1, 0, 0, 32'h0, 0);
    checks++;
    if ({imem_req, imem_addr, fetch_valid} !== {1'b1, 32'h200, 1'b0}) begin
      errors++;
      $display("FAIL bfa_target got req=%b addr=%h want addr 200", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_reset_in_drain();
    set_in(1, 0, 1, 32'h300, 0);
    checks++;
    if ({flush, imem_addr} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL rid_branch got fl=%b addr=%h", flush, imem_addr);
    end
    tick();
    set_in(0, 0, 1, 32'h304, 1);
    checks++;
    if (obs() !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rid_reset got %h want reset values", obs());
    end
    tick();
    set_in(1, 0, 0, 32'h0, 0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL rid_release got req=%b addr=%h want addr 0", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_wrap();
    rst2 = 1'b0; tick();
    rst2 = 1'b1; #1;
    checks++;
    if ({imem_addr2, PC2, fetch_valid2} !== {32'hFFFF_FFFC, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_first got addr=%h pc=%h v=%b", imem_addr2, PC2, fetch_valid2);
    end
    tick();
    checks++;
    if ({imem_addr2, PC2, fetch_valid2} !== {32'h0, 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL wrap_second got addr=%h pc=%h v=%b", imem_addr2, PC2, fetch_valid2);
    end
  endtask

  // Model: pc of the next word to fetch; a frozen fetched word may be held;
  // a branch seen before the outstanding word returns is remembered as a redirect.
  task automatic test_random();
    logic [31:0] m_pc, m_held, m_redirect;
    logic        m_holding, m_redirecting;
    logic        r, f, b, a;
    logic [31:0] ba;
    logic        e_req, e_valid, e_flush;
    logic [31:0] e_addr, e_instr, e_pc;
    set_in(0, 0, 0, 32'h0, 0); tick();
    m_pc = 32'h0; m_held = 32'h0; m_redirect = 32'h0;
    m_holding = 1'b0; m_redirecting = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) != 0);
      f  = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 99) < 15);
      a  = 1'($urandom_range(0, 1));
      ba = $urandom;
      set_in(r, f, b, ba, a);
      e_flush = r && b;
      e_addr  = r ? m_pc : 32'h0;
      e_req   = r && !m_holding;
      if (!r)                 e_valid = 1'b0;
      else if (m_holding)     e_valid = !b;
      else if (m_redirecting) e_valid = 1'b0;
      else                    e_valid = a && !b;
      e_instr = !e_valid ? 32'h0 : (m_holding ? m_held : mem_word(m_pc));
      e_pc    = e_valid ? m_pc + 32'd4 : 32'h0;
      checks++;
      if ({imem_req, fetch_valid, flush, instruction, PC} !== {e_req, e_valid, e_flush, e_instr, e_pc} ||
          (!(r && m_holding) && imem_addr !== e_addr)) begin
        errors++;
        $display("FAIL random[%0d] got req=%b addr=%h v=%b fl=%b ins=%h pc=%h want req=%b addr=%h v=%b fl=%b ins=%h pc=%h",
                 n, imem_req, imem_addr, fetch_valid, flush, instruction, PC,
                 e_req, e_addr, e_valid, e_flush, e_instr, e_pc);
      end
      tick();
      if (!r) begin
        m_pc = 32'h0; m_held = 32'h0; m_redirect = 32'h0;
        m_holding = 1'b0; m_redirecting = 1'b0;
      end else if (m_holding) begin
        if (b)       begin m_pc = ba & ~32'h3; m_holding = 1'b0; end
        else if (!f) begin m_pc = m_pc + 32'd4; m_holding = 1'b0; end
      end else if (m_redirecting) begin
        if (b) m_redirect = ba & ~32'h3;
        if (a) begin m_pc = m_redirect; m_redirecting = 1'b0; end
      end else if (b) begin
        if (a) m_pc = ba & ~32'h3;
        else begin m_redirect = ba & ~32'h3; m_redirecting = 1'b1; end
      end else if (a) begin
        if (f) begin m_held = mem_word(m_pc); m_holding = 1'b1; end
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_freeze();
    test_branch_drain();
    test_branch_freeze_ack();
    test_reset_in_drain();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  system clock; every register updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port freeze  input  1  stall from the hazard unit; 1 = decode stage does not accept this cycle.
REQ-005 SHALL have port branch_taken  input  1  redirect request from the execute stage.
REQ-006 SHALL have port branch_addr  input  32  redirect target; bits [1:0] are ignored and forced to 0.
REQ-007 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-008 SHALL have port imem_addr  output  32  word-aligned read address.
REQ-009 SHALL have port imem_ack  input  1  read data valid; completes the current request.
REQ-010 SHALL have port imem_rdata  input  32  instruction word returned by memory.
REQ-011 SHALL have port PC  output  32  fetch address + 4 of the presented instruction, for the IF/ID register PCIn.
REQ-012 SHALL have port instruction  output  32  presented instruction, for the IF/ID register instructionIn.
REQ-013 SHALL have port fetch_valid  output  1  1 = PC/instruction carry a real fetch.
REQ-014 SHALL have port flush  output  1  IF/ID flush; combinationally equal to branch_taken while rst is high.

Function
REQ-015 SHALL implement the states S_REQ, S_HOLD and S_DRAIN, plus the registers pc_reg, buf_instr and pending_pc.
REQ-016 In S_REQ, the block SHALL drive imem_req=1 and imem_addr=pc_reg.
REQ-017 In S_REQ with imem_ack=1 and no branch, the block SHALL present imem_rdata and pc_reg+4 combinationally with fetch_valid=1 (zero-latency pass-through).
REQ-018 In S_REQ with imem_ack=1, freeze=0 and no branch, the block SHALL update pc_reg<=pc_reg+4 and stay in S_REQ, giving 1 instruction/cycle with a zero-wait memory.
REQ-019 In S_REQ with imem_ack=1, freeze=1 and no branch, the block SHALL capture imem_rdata into buf_instr and go to S_HOLD.
REQ-020 In S_HOLD, the block SHALL drive imem_req=0, instruction=buf_instr, PC=pc_reg+4 and fetch_valid=1; freeze=0 -> pc_reg<=pc_reg+4 and go to S_REQ; freeze=1 -> stay in S_HOLD.
REQ-021 Whenever fetch_valid=0, the block SHALL drive instruction=32'h0 (NOP) and PC=0, so that an unfrozen IF/ID register latches a bubble.
REQ-022 branch_taken=1 SHALL take priority over freeze and over imem_ack in every state.
REQ-023 On a branch in S_HOLD, or in S_REQ with imem_ack=1, the block SHALL discard the fetched word, set pc_reg<={branch_addr[31:2],2'b00} and go to S_REQ.
REQ-024 On a branch in S_REQ with imem_ack=0, the block SHALL store the target in pending_pc and go to S_DRAIN.
REQ-025 In S_DRAIN, the block SHALL hold imem_req=1 and keep imem_addr at the old pc_reg, with fetch_valid=0.
REQ-026 In S_DRAIN, on imem_ack the data SHALL be discarded, pc_reg<=pending_pc, and the state SHALL return to S_REQ.
REQ-027 A further branch in S_DRAIN SHALL overwrite pending_pc; if imem_ack arrives in the same cycle, the new target SHALL be used.
REQ-028 pc_reg+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-029 imem_addr SHALL stay stable while imem_req=1 until imem_ack is seen.

Reset
REQ-030 While rst=0, the block SHALL drive imem_req=0, fetch_valid=0, flush=0, instruction=0, PC=0 and imem_addr=RESET_PC.
REQ-031 While rst=0, the block SHALL load state=S_REQ, pc_reg=RESET_PC, buf_instr=0 and pending_pc=0.
REQ-032 Reset mid-request or mid-drain SHALL abandon the outstanding request; the memory SHALL tolerate imem_req dropping without an ack.
REQ-033 The first request SHALL issue in the first cycle with rst=1.

Structure
REQ-034 defines.v SHALL hold the state encodings, the NOP word (32'h0) and the default RESET_PC.
REQ-035 A sub-module fetch_buffer SHALL hold buf_instr (load enable, synchronous clear); the state machine and PC logic SHALL stay in instr_fetch_unit.

Verification
REQ-036 Scenario: zero-wait memory (ack tied 1), freeze=0, 4 cycles -> imem_addr 0,4,8,C; PC 4,8,C,10; fetch_valid=1 every cycle.
REQ-037 Scenario: freeze=1 for 3 cycles on the ack of addr 8 -> S_HOLD; instruction and PC=C held; imem_req=0; addr C requested in the cycle after freeze drops.
REQ-038 Scenario: branch_taken=1 with branch_addr=32'h103 while a request to 10 is unacked -> flush=1 that cycle; addr stays 10 until ack; data discarded; next imem_addr=32'h100.
REQ-039 Scenario: branch, freeze and ack all high in the same cycle -> the word is not presented (fetch_valid=0); the next request goes to the branch target.
REQ-040 Scenario: RESET_PC=32'hFFFF_FFFC, zero-wait memory -> the second fetch address is 32'h0 and PC outputs are 0 then 4.
REQ-041 Scenario: rst=0 asserted during S_DRAIN -> outputs take the REQ-030 values; the first fetch after release goes to RESET_PC, not pending_pc.
